// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM receive constants and CP-remover state type
package ofdm_pkg;
  localparam int OFDM_N  = 64;
  localparam int OFDM_CP = 16;
  localparam int OFDM_W  = 16;

  typedef enum logic {
    S_CP   = 1'b0,
    S_DATA = 1'b1
  } cp_state_t;
endpackage

// File: rtl/cp_store.sv
// rtl/cp_store.sv - CP-entry register file, one write port, combinational read
module cp_store #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];
endmodule

// File: rtl/cp_remove.sv
// rtl/cp_remove.sv - drops the cyclic prefix, frames N body samples for FFT64
// Macro OFDM_CP_AVG_EN: average the tail body samples with their stored CP copies.
module cp_remove
  import ofdm_pkg::*;
#(
  parameter int N  = OFDM_N,
  parameter int CP = OFDM_CP,
  parameter int W  = OFDM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         di_en,
  input  logic [W-1:0] di_re,
  input  logic [W-1:0] di_im,
  input  logic         sym_sync,
  output logic         do_en,
  output logic [W-1:0] do_re,
  output logic [W-1:0] do_im,
  output logic         do_first,
  output logic         do_last
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  cp_state_t     state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          emit, first, last;
  logic [W-1:0]  out_re, out_im;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CP;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    emit    = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    if (di_en) begin
      if (sym_sync) begin
        // the sync sample is CP index 0; any open symbol is abandoned
        if (CP == 1) begin
          state_n = S_DATA;
          idx_n   = '0;
        end else begin
          state_n = S_CP;
          idx_n   = IW'(1);
        end
      end else begin
        case (state)
          S_CP: begin
            if (idx == IW'(CP - 1)) begin
              state_n = S_DATA;
              idx_n   = '0;
            end else begin
              idx_n = idx + IW'(1);
            end
          end
          S_DATA: begin
            emit  = 1'b1;
            first = (idx == '0);
            last  = (idx == IW'(N - 1));
            if (last) begin
              state_n = S_CP;
              idx_n   = '0;
            end else begin
              idx_n = idx + IW'(1);
            end
          end
          default: begin
            state_n = S_CP;
            idx_n   = '0;
          end
        endcase
      end
    end
  end

`ifdef OFDM_CP_AVG_EN
  localparam int AW = (CP > 1) ? $clog2(CP) : 1;

  logic          st_we, avg_sel;
  logic [AW-1:0] st_wa, st_ra;
  logic [2*W-1:0] st_rd;
  logic [W:0]    sum_re, sum_im;

  assign st_we   = di_en && (sym_sync || state == S_CP);
  assign st_wa   = sym_sync ? '0 : AW'(idx);
  assign st_ra   = AW'(idx - IW'(N - CP));
  assign avg_sel = (state == S_DATA) && (idx >= IW'(N - CP));

  cp_store #(.DEPTH(CP), .AW(AW), .DW(2 * W)) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (st_we),
    .wa    (st_wa),
    .wd    ({di_re, di_im}),
    .ra    (st_ra),
    .rd    (st_rd)
  );

  // W+1-bit sum, dropping the LSB floors toward minus infinity
  assign sum_re = {di_re[W-1], di_re} + {st_rd[2*W-1], st_rd[2*W-1:W]};
  assign sum_im = {di_im[W-1], di_im} + {st_rd[W-1], st_rd[W-1:0]};
  assign out_re = avg_sel ? sum_re[W:1] : di_re;
  assign out_im = avg_sel ? sum_im[W:1] : di_im;
`else
  assign out_re = di_re;
  assign out_im = di_im;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      do_en    <= 1'b0;
      do_first <= 1'b0;
      do_last  <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else begin
      do_en    <= emit;
      do_first <= first;
      do_last  <= last;
      if (emit) begin
        do_re <= out_re;
        do_im <= out_im;
      end
    end
  end
endmodule
